// File: rtl/regfile_pkg.sv
// Shared widths, write-back entry layout and write-enable bit positions
// for the register-file write-back front end.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam int WE_PORT0 = 0;
    localparam int WE_PORT1 = 1;

endpackage

// File: rtl/wb_fifo.sv
// Power-of-two FIFO holding pending write-back entries for one source.
// The pointers carry an extra wrap bit so that full and empty can be told apart.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, wr_d;
    logic [PW:0]  rd_q, rd_d;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign head_o  = mem_q[rd_q[PW-1:0]];

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back front end: buffers ALU and load results, issues them to the two
// register-file write ports without same-register conflicts, and tracks busy regs.
module regfile_writeback #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s0_valid,
    output logic                   s0_ready,
    input  logic [ADDR_W-1:0]      s0_addr,
    input  logic [DATA_W-1:0]      s0_data,
    input  logic                   s1_valid,
    output logic                   s1_ready,
    input  logic [ADDR_W-1:0]      s1_addr,
    input  logic [DATA_W-1:0]      s1_data,
    output logic [1:0]             write_en,
    output logic [ADDR_W-1:0]      reg_write_addr_0,
    output logic [ADDR_W-1:0]      reg_write_addr_1,
    output logic [DATA_W-1:0]      data_in_0,
    output logic [DATA_W-1:0]      data_in_1,
    output logic [(2**ADDR_W)-1:0] busy
);

    import regfile_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;
    localparam int EW    = ADDR_W + DATA_W;
    localparam int CW    = $clog2(2 * DEPTH + 1);

    logic [EW-1:0]     head0, head1;
    logic              full0, full1, empty0, empty1;
    logic              acc0, acc1, pop0, pop1;
    logic [ADDR_W-1:0] h0_addr, h1_addr;
    logic [DATA_W-1:0] h0_data, h1_data;

    logic [1:0]        we_q, we_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [CW-1:0]     cnt_q [NREGS];
    logic [CW-1:0]     cnt_d [NREGS];

    assign s0_ready = ~full0 & ~rst;
    assign s1_ready = ~full1 & ~rst;
    assign acc0     = s0_valid & s0_ready;
    assign acc1     = s1_valid & s1_ready;

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (acc0),
        .data_i  ({s0_addr, s0_data}),
        .pop_i   (pop0),
        .head_o  (head0),
        .full_o  (full0),
        .empty_o (empty0)
    );

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (acc1),
        .data_i  ({s1_addr, s1_data}),
        .pop_i   (pop1),
        .head_o  (head1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    assign h0_addr = head0[EW-1 -: ADDR_W];
    assign h0_data = head0[DATA_W-1:0];
    assign h1_addr = head1[EW-1 -: ADDR_W];
    assign h1_data = head1[DATA_W-1:0];

    // Same destination on both heads: source 0 goes first, source 1 lands last.
    assign pop0 = ~empty0;
    assign pop1 = ~empty1 & ~(~empty0 & (h0_addr == h1_addr));

    always_comb begin
        we_d           = '0;
        we_d[WE_PORT0] = pop0;
        we_d[WE_PORT1] = pop1;
        addr0_d        = pop0 ? h0_addr : addr0_q;
        data0_d        = pop0 ? h0_data : data0_q;
        addr1_d        = pop1 ? h1_addr : addr1_q;
        data1_d        = pop1 ? h1_data : data1_q;
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r]
                     + CW'(acc0 && (s0_addr == ADDR_W'(r)))
                     + CW'(acc1 && (s1_addr == ADDR_W'(r)))
                     - CW'(pop0 && (h0_addr == ADDR_W'(r)))
                     - CW'(pop1 && (h1_addr == ADDR_W'(r)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= '0;
            addr0_q <= '0;
            addr1_q <= '0;
            data0_q <= '0;
            data1_q <= '0;
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
        end else begin
            we_q    <= we_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // A register stays busy until the write sitting in the output register is captured.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy[r] = (cnt_q[r] != '0)
                    | (we_q[WE_PORT0] & (addr0_q == ADDR_W'(r)))
                    | (we_q[WE_PORT1] & (addr1_q == ADDR_W'(r)));
        end
    end

    assign write_en         = we_q;
    assign reg_write_addr_0 = addr0_q;
    assign reg_write_addr_1 = addr1_q;
    assign data_in_0        = data0_q;
    assign data_in_1        = data1_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: accepted entries are queued per source
// and a negedge monitor matches every issued write against them.
module tb_regfile_writeback;

    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [2:0]  s0_addr, s1_addr;
    logic [15:0] s0_data, s1_data;
    logic [1:0]  write_en;
    logic [2:0]  reg_write_addr_0, reg_write_addr_1;
    logic [15:0] data_in_0, data_in_1;
    logic [7:0]  busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wb_entry_t   exp0[$];
    wb_entry_t   exp1[$];
    logic [15:0] rf [8];

    regfile_writeback #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .s0_valid         (s0_valid),
        .s0_ready         (s0_ready),
        .s0_addr          (s0_addr),
        .s0_data          (s0_data),
        .s1_valid         (s1_valid),
        .s1_ready         (s1_ready),
        .s1_addr          (s1_addr),
        .s1_data          (s1_data),
        .write_en         (write_en),
        .reg_write_addr_0 (reg_write_addr_0),
        .reg_write_addr_1 (reg_write_addr_1),
        .data_in_0        (data_in_0),
        .data_in_1        (data_in_1),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file being written
    always @(posedge clk) begin
        if (write_en[0]) rf[reg_write_addr_0] <= data_in_0;
        if (write_en[1]) rf[reg_write_addr_1] <= data_in_1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (write_en[0]) begin
                if (exp0.size() == 0) begin
                    total_cnt++;
                    $display("FAIL port0_unexpected: got write addr %0d data %h, expected no write",
                             reg_write_addr_0, data_in_0);
                end else begin
                    wb_entry_t e;
                    e = exp0.pop_front();
                    chk("port0_write", 32'({reg_write_addr_0, data_in_0}), 32'({e.addr, e.data}));
                end
            end
            if (write_en[1]) begin
                if (exp1.size() == 0) begin
                    total_cnt++;
                    $display("FAIL port1_unexpected: got write addr %0d data %h, expected no write",
                             reg_write_addr_1, data_in_1);
                end else begin
                    wb_entry_t e;
                    e = exp1.pop_front();
                    chk("port1_write", 32'({reg_write_addr_1, data_in_1}), 32'({e.addr, e.data}));
                end
            end
            if (write_en == 2'b11)
                chk("no_same_addr_dual", 32'(reg_write_addr_0 != reg_write_addr_1), 32'd1);
        end
    end

    // One cycle of stimulus; ready is sampled mid-cycle where it is stable before the edge.
    task automatic drive(input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                         input logic v1, input logic [2:0] a1, input logic [15:0] d1,
                         output logic acc0, output logic acc1, output logic [7:0] busy_mid);
        s0_valid = v0; s0_addr = a0; s0_data = d0;
        s1_valid = v1; s1_addr = a1; s1_data = d1;
        @(negedge clk);
        busy_mid = busy;
        acc0 = v0 & s0_ready;
        acc1 = v1 & s1_ready;
        @(posedge clk);
        if (acc0) exp0.push_back('{addr: a0, data: d0});
        if (acc1) exp1.push_back('{addr: a1, data: d1});
        #1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       a0, a1;
        logic [7:0] bm;
        int         n1;

        rst = 1'b1;
        s0_valid = 0; s0_addr = 0; s0_data = 0;
        s1_valid = 0; s1_addr = 0; s1_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'({s1_ready, s0_ready}), 32'd0);
        chk("rst_addr_data0", 32'({reg_write_addr_0, data_in_0}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'({s1_ready, s0_ready}), 32'b11);
        @(posedge clk); #1;

        // Single write
        drive(1, 3'd2, 16'h1234, 0, 3'd0, 16'h0, a0, a1, bm);
        @(negedge clk);
        chk("single_we_n", 32'(write_en), 32'b00);
        chk("single_busy_n", 32'(busy), 32'h04);
        @(negedge clk);
        chk("single_we_n1", 32'(write_en), 32'b01);
        chk("single_busy_n1", 32'(busy), 32'h04);
        @(negedge clk);
        chk("single_we_n2", 32'(write_en), 32'b00);
        chk("single_busy_n2", 32'(busy), 32'h00);
        chk("single_rf2", 32'(rf[2]), 32'h1234);
        @(posedge clk); #1;
        idle(2);

        // Dual write, different registers
        drive(1, 3'd5, 16'h5678, 1, 3'd3, 16'h1010, a0, a1, bm);
        @(negedge clk);
        chk("dual_busy_n", 32'(busy), 32'h28);
        @(negedge clk);
        chk("dual_we_n1", 32'(write_en), 32'b11);
        chk("dual_busy_n1", 32'(busy), 32'h28);
        @(negedge clk);
        chk("dual_busy_n2", 32'(busy), 32'h00);
        chk("dual_rf", 32'({rf[5], rf[3]}), 32'h5678_1010);
        @(posedge clk); #1;
        idle(2);

        // Collision on register 2
        drive(1, 3'd2, 16'h2345, 1, 3'd2, 16'hBEEF, a0, a1, bm);
        @(negedge clk);
        chk("coll_busy_n", 32'(busy), 32'h04);
        @(negedge clk);
        chk("coll_we_n1", 32'(write_en), 32'b01);
        chk("coll_data0_n1", 32'(data_in_0), 32'h2345);
        @(negedge clk);
        chk("coll_we_n2", 32'(write_en), 32'b10);
        chk("coll_port1_n2", 32'({reg_write_addr_1, data_in_1}), 32'({3'd2, 16'hBEEF}));
        chk("coll_data0_hold", 32'(data_in_0), 32'h2345);
        chk("coll_busy_n2", 32'(busy), 32'h04);
        @(negedge clk);
        chk("coll_we_n3", 32'(write_en), 32'b00);
        chk("coll_busy_n3", 32'(busy), 32'h00);
        chk("coll_rf2", 32'(rf[2]), 32'hBEEF);
        @(posedge clk); #1;
        idle(2);

        // Backpressure: source 0 keeps register 4 busy so head 1 cannot leave
        n1 = 0;
        for (int c = 0; c < 30; c++) begin
            if (c >= 8 && n1 >= 6) break;
            drive(c < 8, 3'd4, 16'(16'h0C00 + c), n1 < 6, 3'd4, 16'(16'hA000 + n1), a0, a1, bm);
            if (a1) n1++;
            if (c == 5) begin
                chk("bp_s1_accepted", 32'(n1), 32'd4);
                chk("bp_s1_ready_low", 32'(s1_ready), 32'd0);
            end
        end
        chk("bp_s1_total", 32'(n1), 32'd6);
        idle(12);
        chk("bp_drained", 32'(exp0.size() + exp1.size()), 32'd0);
        chk("bp_busy_clear", 32'(busy), 32'h00);
        chk("bp_rf4_last", 32'(rf[4]), 32'hA005);

        // Three back-to-back writes to register 7
        drive(1, 3'd7, 16'h0701, 0, 3'd0, 16'h0, a0, a1, bm);
        drive(1, 3'd7, 16'h0702, 0, 3'd0, 16'h0, a0, a1, bm);
        chk("cnt_busy_n", 32'(bm), 32'h80);
        drive(1, 3'd7, 16'h0703, 0, 3'd0, 16'h0, a0, a1, bm);
        chk("cnt_busy_n1", 32'(bm), 32'h80);
        @(negedge clk);
        chk("cnt_busy_n2", 32'(busy), 32'h80);
        @(negedge clk);
        chk("cnt_busy_n3", 32'(busy), 32'h80);
        @(negedge clk);
        chk("cnt_busy_n4", 32'(busy), 32'h00);
        chk("cnt_rf7", 32'(rf[7]), 32'h0703);
        @(posedge clk); #1;
        idle(2);

        // Reset with three entries queued
        drive(1, 3'd1, 16'h1111, 1, 3'd1, 16'h6666, a0, a1, bm);
        drive(1, 3'd1, 16'h2222, 1, 3'd1, 16'h7777, a0, a1, bm);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_we", 32'(write_en), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'({s1_ready, s0_ready}), 32'd0);
        chk("mrst_port0", 32'({reg_write_addr_0, data_in_0}), 32'd0);
        chk("mrst_port1", 32'({reg_write_addr_1, data_in_1}), 32'd0);
        exp0.delete();
        exp1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ready_after", 32'({s1_ready, s0_ready}), 32'b11);
        chk("mrst_busy_after", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mrst_no_stale_we", 32'(write_en), 32'd0);
        end
        chk("final_queues_empty", 32'(exp0.size() + exp1.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
